// File: rtl/instr_issue_ctrl_pkg.sv
// Shared definitions for the instruction issue controller.
//  - Fixed 18-bit instruction layout (bit positions of every field).
//  - Opcode constants (only NOP changes sequencing).
//  - FSM state encoding and the decoded-field struct.
package instr_issue_ctrl_pkg;

    localparam int INSTR_W_FIXED = 18;

    // Field bit positions inside the instruction register.
    localparam int OPC_MSB  = 17;
    localparam int OPC_LSB  = 15;
    localparam int DEST_MSB = 14;
    localparam int DEST_LSB = 11;
    localparam int A1_MSB   = 10;
    localparam int A1_LSB   = 7;
    localparam int SIMM_BIT = 6;
    localparam int IMM_MSB  = 5;
    localparam int IMM_LSB  = 0;
    // addr2 aliases the low nibble of the immediate field.
    localparam int A2_MSB   = 3;
    localparam int A2_LSB   = 0;

    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0] opcode;
        logic [3:0] dest;
        logic [3:0] addr1;
        logic [3:0] addr2;
        logic       sinal_imm;
        logic [5:0] imm;
    } fields_t;

    function automatic logic is_nop(input logic [2:0] op);
        return op == OP_NOP;
    endfunction

endpackage

// File: rtl/instr_issue_ctrl_if.sv
// Bundle between the instruction source and the issue controller, plus the
// decoded fields / write enable the controller drives towards the bank.
//
// Handshake: a word transfers on a rising clk edge where instr_valid and
// instr_ready are both high. instr_ready is high only while the controller
// is idle; the source may change or drop instr at any time while
// instr_ready is low, and such words are ignored.
//
// Modports:
//  master : instruction source (drives instr_valid/instr, observes the rest)
//  slave  : controller (drives instr_ready, fields, we, busy, done, count)
interface instr_issue_ctrl_if #(
    parameter int INSTR_W = 18,
    parameter int CNT_W   = 8
);
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [2:0]         opcode;
    logic [3:0]         addr1;
    logic [3:0]         addr2;
    logic [3:0]         dest;
    logic               sinalImm;
    logic [5:0]         Imm;
    logic               we;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        output instr_valid, instr,
        input  instr_ready, opcode, addr1, addr2, dest, sinalImm, Imm,
               we, busy, done, instr_count
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, opcode, addr1, addr2, dest, sinalImm, Imm,
               we, busy, done, instr_count
    );
endinterface

// File: rtl/instr_issue_ctrl_fields.sv
// Pure combinational splitter: instruction register -> named fields.
// Ports:
//  ir     in   18-bit instruction word
//  fields out  decoded opcode/dest/addr1/addr2/sinal_imm/imm
module instr_fields
    import instr_issue_ctrl_pkg::*;
(
    input  logic [INSTR_W_FIXED-1:0] ir,
    output fields_t                  fields
);

    always_comb begin
        fields.opcode    = ir[OPC_MSB:OPC_LSB];
        fields.dest      = ir[DEST_MSB:DEST_LSB];
        fields.addr1     = ir[A1_MSB:A1_LSB];
        fields.addr2     = ir[A2_MSB:A2_LSB];
        fields.sinal_imm = ir[SIMM_BIT];
        fields.imm       = ir[IMM_MSB:IMM_LSB];
    end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Instruction issue controller: accepts one instruction per handshake,
// holds it in IR, and sequences the bank through
// IDLE -> DECODE -> EXEC -> WRITE -> RELEASE -> IDLE (WRITE skipped for NOP).
// Ports:
//  clk        in   rising-edge clock
//  rst_n      in   asynchronous active-low reset
//  bus        slave modport: instr_valid/instr in; instr_ready, fields,
//             we, busy, done, instr_count out
//  dbg_state  out  current FSM state
module instr_issue_ctrl
    import instr_issue_ctrl_pkg::*;
#(
    parameter int INSTR_W  = 18,
    parameter int EXEC_CYC = 1,
    parameter int WE_CYC   = 2,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_issue_ctrl_if.slave    bus,
    output state_e               dbg_state
);

    if (INSTR_W != INSTR_W_FIXED) begin : g_bad_instr_w
        $error("instr_issue_ctrl: INSTR_W must be 18");
    end
    if (EXEC_CYC < 1) begin : g_bad_exec_cyc
        $error("instr_issue_ctrl: EXEC_CYC must be >= 1");
    end
    if (WE_CYC < 2) begin : g_bad_we_cyc
        $error("instr_issue_ctrl: WE_CYC must be >= 2");
    end

    // One down-counter serves both EXEC and WRITE phases.
    localparam int PH_MAX = (EXEC_CYC > WE_CYC) ? EXEC_CYC : WE_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_e             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    fields_t            fields;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
                ph_d    = PH_W'(EXEC_CYC - 1);
            end
            ST_EXEC: begin
                if (ph_q == '0) begin
                    if (is_nop(fields.opcode)) begin
                        state_d = ST_RELEASE;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                        ph_d    = PH_W'(WE_CYC - 1);
                    end
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            ST_WRITE: begin
                if (ph_q == '0) begin
                    state_d = ST_RELEASE;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered from the next state so they line up with
        // the state they describe; the count steps together with done.
        we_d   = (state_d == ST_WRITE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_RELEASE);
    end

    instr_fields u_fields (
        .ir     (ir_q),
        .fields (fields)
    );

    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.opcode      = fields.opcode;
    assign bus.dest        = fields.dest;
    assign bus.addr1       = fields.addr1;
    assign bus.addr2       = fields.addr2;
    assign bus.sinalImm    = fields.sinal_imm;
    assign bus.Imm         = fields.imm;
    assign bus.we          = we_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.instr_count = cnt_q;
    assign dbg_state       = state_q;

endmodule
